// File: rtl/vedic_pkg.sv
// rtl/vedic_pkg.sv - shared widths, FSM state type and limb-index helper for vedic_mult64_seq
package vedic_pkg;

  localparam int LIMB_W = 16;
  localparam int OP_W   = 64;
  localparam int PROD_W = 128;
  localparam int MU_W   = 31;
  localparam int K_W    = 8;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  typedef struct packed {
    logic [1:0] i;
    logic [1:0] j;
  } limb_sel_t;

  // Partial product n pairs a-limb n[3:2] with b-limb n[1:0].
  function automatic limb_sel_t limb_sel(input logic [3:0] n);
    limb_sel_t s;
    s.i = n[3:2];
    s.j = n[1:0];
    return s;
  endfunction

endpackage

// File: rtl/vedic_mult16.sv
// rtl/vedic_mult16.sv - combinational 16x16->32 Urdhva-Tiryagbhyam multiplier cell
module vedic_mult16
  import vedic_pkg::*;
(
  input  logic [LIMB_W-1:0]   a_i,
  input  logic [LIMB_W-1:0]   b_i,
  output logic [2*LIMB_W-1:0] p_o
);

  // Column k gathers every crosswise bit product a[x]&b[k-x]; columns are then added at weight 2^k.
  always_comb begin
    logic [2*LIMB_W-1:0] sum;
    logic [2*LIMB_W-1:0] col;
    int                  y;
    sum = '0;
    col = '0;
    y   = 0;
    for (int k = 0; k < 2*LIMB_W-1; k++) begin
      col = '0;
      for (int x = 0; x < LIMB_W; x++) begin
        y = k - x;
        if (y >= 0 && y < LIMB_W) begin
          col = col + {{(2*LIMB_W-1){1'b0}}, a_i[x] & b_i[y[3:0]]};
        end
      end
      sum = sum + (col << k);
    end
    p_o = sum;
  end

endmodule

// File: rtl/vedic_mult64_seq.sv
// rtl/vedic_mult64_seq.sv - iterative 64x64 multiplier feeding the Barrett reducer, sideband forwarded with z
// Optional zero-operand shortcut enabled by defining VEDIC_ZERO_BYPASS_EN.
module vedic_mult64_seq
  import vedic_pkg::*;
#(
  parameter int PP_PER_CYCLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  input  logic [OP_W-1:0]   q_in,
  input  logic [MU_W-1:0]   mu_in,
  input  logic [K_W-1:0]    k_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] z,
  output logic [OP_W-1:0]   q_out,
  output logic [MU_W-1:0]   mu_out,
  output logic [K_W-1:0]    k_out,
  output logic              busy
);

  localparam int NUM_PP = 16;

  if (!(PP_PER_CYCLE == 1 || PP_PER_CYCLE == 2 || PP_PER_CYCLE == 4 ||
        PP_PER_CYCLE == 8 || PP_PER_CYCLE == 16)) begin : g_bad_pp
    $error("vedic_mult64_seq: PP_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  state_t            state_q;
  logic [OP_W-1:0]   a_q, b_q;
  logic [PROD_W-1:0] acc_q, acc_d;
  logic [4:0]        idx_q;
  logic [OP_W-1:0]   q_lat_q;
  logic [MU_W-1:0]   mu_lat_q;
  logic [K_W-1:0]    k_lat_q;
  logic [PROD_W-1:0] z_q;
  logic [OP_W-1:0]   q_out_q;
  logic [MU_W-1:0]   mu_out_q;
  logic [K_W-1:0]    k_out_q;
  logic              out_valid_q;

  logic [PROD_W-1:0] pp_shifted [PP_PER_CYCLE];

  for (genvar p = 0; p < PP_PER_CYCLE; p++) begin : g_cell
    limb_sel_t           sel;
    logic [2*LIMB_W-1:0] pp;

    assign sel = limb_sel(idx_q[3:0] + 4'(p));

    vedic_mult16 u_cell (
      .a_i (a_q[LIMB_W*sel.i +: LIMB_W]),
      .b_i (b_q[LIMB_W*sel.j +: LIMB_W]),
      .p_o (pp)
    );

    assign pp_shifted[p] = PROD_W'(pp) << (LIMB_W * (int'(sel.i) + int'(sel.j)));
  end

  always_comb begin
    acc_d = acc_q;
    for (int p = 0; p < PP_PER_CYCLE; p++) begin
      acc_d = acc_d + pp_shifted[p];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      q_lat_q     <= '0;
      mu_lat_q    <= '0;
      k_lat_q     <= '0;
      z_q         <= '0;
      q_out_q     <= '0;
      mu_out_q    <= '0;
      k_out_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            q_lat_q  <= q_in;
            mu_lat_q <= mu_in;
            k_lat_q  <= k_in;
            acc_q    <= '0;
            idx_q    <= '0;
`ifdef VEDIC_ZERO_BYPASS_EN
            state_q  <= (a == '0 || b == '0) ? DONE : ACCUM;
`else
            state_q  <= ACCUM;
`endif
          end
        end
        ACCUM: begin
          acc_q <= acc_d;
          idx_q <= idx_q + 5'(PP_PER_CYCLE);
          if (idx_q + 5'(PP_PER_CYCLE) == 5'(NUM_PP)) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          // First DONE cycle publishes the result; afterwards it is held until taken.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            z_q         <= acc_q;
            q_out_q     <= q_lat_q;
            mu_out_q    <= mu_lat_q;
            k_out_q     <= k_lat_q;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign z         = z_q;
  assign q_out     = q_out_q;
  assign mu_out    = mu_out_q;
  assign k_out     = k_out_q;

endmodule

// File: tb/tb_vedic_mult64_seq.sv
// tb/tb_vedic_mult64_seq.sv - self-checking bench for vedic_mult64_seq against a plain a*b reference
module tb_vedic_mult64_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid, in_valid4;
  logic [63:0]  a, b, q_in;
  logic [30:0]  mu_in;
  logic [7:0]   k_in;
  logic         out_ready, out_ready4;

  logic         in_ready, out_valid, busy;
  logic [127:0] z;
  logic [63:0]  q_out;
  logic [30:0]  mu_out;
  logic [7:0]   k_out;

  logic         in_ready4, out_valid4, busy4;
  logic [127:0] z4;
  logic [63:0]  q_out4;
  logic [30:0]  mu_out4;
  logic [7:0]   k_out4;

  int checks = 0;
  int errors = 0;

`ifdef VEDIC_ZERO_BYPASS_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = 17;
`endif

  vedic_mult64_seq #(.PP_PER_CYCLE(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .q_in(q_in), .mu_in(mu_in), .k_in(k_in),
    .out_valid(out_valid), .out_ready(out_ready), .z(z),
    .q_out(q_out), .mu_out(mu_out), .k_out(k_out), .busy(busy)
  );

  vedic_mult64_seq #(.PP_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a), .b(b), .q_in(q_in), .mu_in(mu_in), .k_in(k_in),
    .out_valid(out_valid4), .out_ready(out_ready4), .z(z4),
    .q_out(q_out4), .mu_out(mu_out4), .k_out(k_out4), .busy(busy4)
  );

  function automatic logic [127:0] ref_mul(input logic [63:0] x, input logic [63:0] y);
    return {64'd0, x} * {64'd0, y};
  endfunction

  function automatic logic [63:0] rand_op();
    int unsigned pick;
    pick = $urandom_range(0, 15);
    if (pick == 0) return 64'd0;
    if (pick == 1) return {64{1'b1}};
    return {$urandom, $urandom};
  endfunction

  // Presents one operation for one edge; returns clocks from the accepting edge until out_valid is seen.
  task automatic run_op(input bit use4, input logic [63:0] ta, input logic [63:0] tb,
                        input logic [63:0] tq, input logic [30:0] tmu, input logic [7:0] tk,
                        output int lat);
    a = ta; b = tb; q_in = tq; mu_in = tmu; k_in = tk;
    if (use4) in_valid4 = 1'b1; else in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_valid4 = 1'b0;
    lat = 0;
    while (!(use4 ? out_valid4 : out_valid) && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (z !== 128'd0) begin errors++; $display("FAIL reset_z got %h exp 0", z); end
    checks++;
    if ({q_out, mu_out, k_out} !== 103'd0) begin
      errors++; $display("FAIL reset_sideband got %h %h %h exp 0", q_out, mu_out, k_out);
    end
    checks++; if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0) begin
      errors++; $display("FAIL reset_pp4 got in_ready %b out_valid %b exp 1 0", in_ready4, out_valid4);
    end
  endtask

  task automatic test_basic();
    int lat;
    out_ready = 1'b1;
    run_op(1'b0, 64'd3, 64'd5, 64'hFFFFFFFF00000001, 31'd7, 8'd64, lat);
    checks++; if (lat !== 17) begin errors++; $display("FAIL basic_latency got %0d exp 17", lat); end
    checks++; if (z !== 128'd15) begin errors++; $display("FAIL basic_z got %h exp %h", z, 128'd15); end
    checks++;
    if (q_out !== 64'hFFFFFFFF00000001 || mu_out !== 31'd7 || k_out !== 8'd64) begin
      errors++; $display("FAIL basic_sideband got %h %h %h exp ffffffff00000001 7 40", q_out, mu_out, k_out);
    end
    checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL basic_done_flags got busy %b in_ready %b exp 1 0", busy, in_ready);
    end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL basic_release got out_valid %b in_ready %b exp 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_max();
    int lat;
    logic [63:0] m;
    m = {64{1'b1}};
    out_ready = 1'b1; out_ready4 = 1'b1;
    run_op(1'b0, m, m, 64'h5, 31'h7FFFFFFF, 8'hFF, lat);
    checks++; if (lat !== 17) begin errors++; $display("FAIL max_latency got %0d exp 17", lat); end
    checks++; if (z !== ref_mul(m, m)) begin errors++; $display("FAIL max_z got %h exp %h", z, ref_mul(m, m)); end
    @(posedge clk); #1;
    run_op(1'b1, m, m, 64'h5, 31'h7FFFFFFF, 8'hFF, lat);
    checks++; if (lat !== 5) begin errors++; $display("FAIL max_pp4_latency got %0d exp 5", lat); end
    checks++; if (z4 !== ref_mul(m, m)) begin errors++; $display("FAIL max_pp4_z got %h exp %h", z4, ref_mul(m, m)); end
    checks++; if (mu_out4 !== 31'h7FFFFFFF) begin errors++; $display("FAIL max_pp4_mu got %h exp 7fffffff", mu_out4); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    logic [127:0] exp_z;
    exp_z = ref_mul(64'h123456789ABCDEF0, 64'h10);
    out_ready = 1'b0;
    run_op(1'b0, 64'h123456789ABCDEF0, 64'h10, 64'hA, 31'd3, 8'd9, lat);
    checks++; if (lat !== 17) begin errors++; $display("FAIL bp_latency got %0d exp 17", lat); end
    bad = 0;
    a = 64'hFFFF; b = 64'hFFFF; in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (z !== exp_z || out_valid !== 1'b1 || in_ready !== 1'b0 || k_out !== 8'd9) bad++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++; if (bad !== 0) begin errors++; $display("FAIL bp_hold got %0d unstable cycles exp 0 (z %h exp %h)", bad, z, exp_z); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (out_valid !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL bp_single_transfer got %0d extra valid cycles exp 0", bad); end
  endtask

  task automatic test_reset_mid();
    int lat;
    int stale;
    out_ready = 1'b1;
    a = 64'hDEADBEEF; b = 64'h12345; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before got %b exp 1", busy); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || z !== 128'd0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL mid_reset got busy %b ov %b z %h rdy %b exp 0 0 0 1", busy, out_valid, z, in_ready);
    end
    stale = 0;
    for (int i = 0; i < 25; i++) begin
      if (out_valid !== 1'b0) stale++;
      @(posedge clk); #1;
    end
    checks++; if (stale !== 0) begin errors++; $display("FAIL mid_stale got %0d valid cycles exp 0", stale); end
    run_op(1'b0, 64'd2, 64'd2, 64'd0, 31'd0, 8'd0, lat);
    checks++; if (lat !== 17 || z !== 128'd4) begin
      errors++; $display("FAIL mid_after got lat %0d z %h exp 17 4", lat, z);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_zero();
    int lat;
    out_ready = 1'b1;
    run_op(1'b0, 64'd0, 64'hDEAD, 64'h77, 31'd1, 8'd2, lat);
    checks++; if (lat !== ZERO_LAT) begin errors++; $display("FAIL zero_a_latency got %0d exp %0d", lat, ZERO_LAT); end
    checks++; if (z !== 128'd0 || q_out !== 64'h77) begin errors++; $display("FAIL zero_a_z got %h q %h exp 0 77", z, q_out); end
    @(posedge clk); #1;
    run_op(1'b0, 64'hBEEF, 64'd0, 64'h78, 31'd1, 8'd2, lat);
    checks++; if (lat !== ZERO_LAT || z !== 128'd0) begin
      errors++; $display("FAIL zero_b got lat %0d z %h exp %0d 0", lat, z, ZERO_LAT);
    end
    @(posedge clk); #1;
  endtask

  typedef struct packed {
    logic [127:0] z;
    logic [63:0]  q;
    logic [30:0]  mu;
    logic [7:0]   k;
  } exp_t;

  task automatic test_back_to_back();
    exp_t expq[$];
    exp_t e;
    int sent, recv, cyc;
    sent = 0; recv = 0; cyc = 0;
    while ((sent < 1000 || recv < sent) && cyc < 60000) begin
      if (sent < 1000) begin
        in_valid = ($urandom_range(0, 3) != 0);
        a = rand_op(); b = rand_op();
        q_in = {$urandom, $urandom}; mu_in = 31'($urandom); k_in = 8'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 2) != 0);
      if (in_valid && in_ready) begin
        expq.push_back('{z: ref_mul(a, b), q: q_in, mu: mu_in, k: k_in});
        sent++;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (expq.size() == 0) begin
          errors++; $display("FAIL b2b_unexpected got z %h exp no transfer", z);
        end else begin
          e = expq.pop_front();
          if ({z, q_out, mu_out, k_out} !== {e.z, e.q, e.mu, e.k}) begin
            errors++; $display("FAIL b2b_result #%0d got z %h q %h mu %h k %h exp z %h q %h mu %h k %h",
                               recv, z, q_out, mu_out, k_out, e.z, e.q, e.mu, e.k);
          end
        end
        recv++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (sent !== 1000 || recv !== 1000 || expq.size() !== 0) begin
      errors++; $display("FAIL b2b_count got sent %0d recv %0d pending %0d exp 1000 1000 0", sent, recv, expq.size());
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_valid4 = 1'b0;
    a = '0; b = '0; q_in = '0; mu_in = '0; k_in = '0;
    out_ready = 1'b1; out_ready4 = 1'b1;
    test_reset();
    test_basic();
    test_max();
    test_backpressure();
    test_reset_mid();
    test_zero();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
